// File: rtl/acc_offload_tracker.sv
// acc_offload_tracker: issues core offloads as C requests and pairs in-order C responses with their destination registers
package acc_offload_pkg;
  typedef struct packed {
    logic [31:0] insn;
    logic [7:0]  tag;
  } acc_c_req_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } acc_c_rsp_chan_t;
  typedef struct packed {
    acc_c_req_chan_t q;
    logic            q_valid;
    logic            p_ready;
  } acc_c_req_t;
  typedef struct packed {
    acc_c_rsp_chan_t p;
    logic            p_valid;
    logic            q_ready;
  } acc_c_rsp_t;
endpackage

module acc_offload_tracker #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter type acc_c_req_t = acc_offload_pkg::acc_c_req_t,
  parameter type acc_c_req_chan_t = acc_offload_pkg::acc_c_req_chan_t,
  parameter type acc_c_rsp_t = acc_offload_pkg::acc_c_rsp_t,
  localparam int unsigned OW = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  acc_c_req_chan_t      core_q_i,
  input  logic                 core_q_valid_i,
  output logic                 core_q_ready_o,
  input  logic [4:0]           core_rs1_i,
  input  logic [4:0]           core_rs2_i,
  input  logic [4:0]           core_rd_i,
  input  logic                 core_wb_i,
  output acc_c_req_t           acc_req_o,
  input  acc_c_rsp_t           acc_rsp_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [4:0]           wb_rd_o,
  output logic [DataWidth-1:0] wb_data_o,
  output logic                 wb_error_o,
  output logic [31:0]          busy_o,
  output logic [OW-1:0]        outstanding_o,
  output logic                 unexpected_rsp_o
);
  localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam logic [PW-1:0] LAST = PW'(MaxOutstanding - 1);
  logic [31:0]   busy_q;
  logic [4:0]    fifo_q [MaxOutstanding];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] cnt_q;
  logic          unexp_q;
  logic          hazard, full, empty, push, retire;
  assign hazard = busy_q[core_rs1_i] | busy_q[core_rs2_i] | (core_wb_i & busy_q[core_rd_i]);
  assign full = core_wb_i & (cnt_q == OW'(MaxOutstanding));
  assign empty = cnt_q == '0;
  assign core_q_ready_o = acc_rsp_i.q_ready & ~hazard & ~full;
  assign push = core_q_valid_i & core_q_ready_o & core_wb_i;
  assign wb_valid_o = ~empty & acc_rsp_i.p_valid;
  assign retire = wb_valid_o & wb_ready_i;
  assign wb_rd_o = fifo_q[rd_ptr_q];
  assign wb_data_o = DataWidth'(acc_rsp_i.p.data);
  assign wb_error_o = acc_rsp_i.p.error;
  assign busy_o = busy_q;
  assign outstanding_o = cnt_q;
  assign unexpected_rsp_o = unexp_q;
  // request passthrough; responses drain freely while nothing is outstanding
  always_comb begin
    acc_req_o.q = core_q_i;
    acc_req_o.q_valid = core_q_valid_i & ~hazard & ~full;
    acc_req_o.p_ready = empty | wb_ready_i;
  end
  // scoreboard: a new destination overrides a retiring one; x0 is never tracked
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) busy_q <= '0;
    else begin
      if (retire) busy_q[wb_rd_o] <= 1'b0;
      if (push && core_rd_i != 5'd0) busy_q[core_rd_i] <= 1'b1;
    end
  // destination register storage; contents are meaningless while the count is zero
  always_ff @(posedge clk_i)
    if (push) fifo_q[wr_ptr_q] <= core_rd_i;
  // circular pointers, occupancy count and sticky orphan-response flag
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      unexp_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1;
      if (retire) rd_ptr_q <= rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + OW'(push) - OW'(retire);
      if (empty && acc_rsp_i.p_valid) unexp_q <= 1'b1;
    end
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) retire |-> !empty);
  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= OW'(MaxOutstanding));
  a_wb_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    wb_valid_o && !wb_ready_i |=> wb_valid_o && $stable(wb_rd_o) && $stable(wb_data_o) && $stable(wb_error_o));
endmodule

// File: tb/tb_acc_offload_tracker.sv
// tb_acc_offload_tracker: directed and random checks of acc_offload_tracker against a queue-based model
module tb_acc_offload_tracker;
  localparam int MAXO = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  acc_offload_pkg::acc_c_req_chan_t core_q;
  acc_offload_pkg::acc_c_req_t acc_req;
  acc_offload_pkg::acc_c_rsp_t acc_rsp;
  logic core_q_valid, core_q_ready, core_wb, wb_valid, wb_ready, wb_error, unexp;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic [31:0] wb_data, busy;
  logic [2:0] outstanding;
  int total = 0, bad = 0;
  bit [4:0] mq[$];
  bit unexp_m = 0, hold = 0;
  bit [31:0] last_d;
  bit last_e;

  acc_offload_tracker #(.DataWidth(32), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_q_i(core_q), .core_q_valid_i(core_q_valid),
    .core_q_ready_o(core_q_ready), .core_rs1_i(rs1), .core_rs2_i(rs2), .core_rd_i(rd),
    .core_wb_i(core_wb), .acc_req_o(acc_req), .acc_rsp_i(acc_rsp), .wb_valid_o(wb_valid),
    .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_error_o(wb_error),
    .busy_o(busy), .outstanding_o(outstanding), .unexpected_rsp_o(unexp)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_m();
    busy_m = '0;
    foreach (mq[i]) if (mq[i] != 5'd0) busy_m[mq[i]] = 1'b1;
  endfunction

  task automatic cyc(input bit v, input bit wb, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] d_rd,
                     input bit qr, input bit pv, input bit wr, input bit [31:0] d, input bit e);
    logic [31:0] bm;
    logic [39:0] qp;
    bit hz, fl, em, qrd, wbv;
    qp = {32'($urandom()), 8'($urandom())};
    core_q = qp; core_q_valid = v; core_wb = wb; rs1 = r1; rs2 = r2; rd = d_rd;
    acc_rsp.q_ready = qr; acc_rsp.p_valid = pv; acc_rsp.p.data = d; acc_rsp.p.error = e; wb_ready = wr;
    bm = busy_m();
    hz = bm[r1] | bm[r2] | (wb & bm[d_rd]);
    fl = wb && mq.size() == MAXO;
    em = mq.size() == 0;
    qrd = qr & !hz & !fl;
    wbv = !em & pv;
    #3;
    chk("busy", busy, bm);
    chk("outstanding", outstanding, mq.size());
    chk("unexpected", unexp, unexp_m);
    chk("q_ready", core_q_ready, qrd);
    chk("q_valid", acc_req.q_valid, v & !hz & !fl);
    chk("q_payload", acc_req.q, qp);
    chk("p_ready", acc_req.p_ready, em | wr);
    chk("wb_valid", wb_valid, wbv);
    if (wbv) begin
      chk("wb_rd", wb_rd, mq[0]);
      chk("wb_data", wb_data, d);
      chk("wb_error", wb_error, e);
    end
    @(posedge clk_i);
    #1;
    if (wbv && wr) void'(mq.pop_front());
    if (v && qrd && wb) mq.push_back(d_rd);
    if (pv && em) unexp_m = 1;
    hold = wbv & !wr;
    last_d = d;
    last_e = e;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
  endtask

  initial begin
    core_q = '0; core_q_valid = 0; core_wb = 0; rs1 = 0; rs2 = 0; rd = 0;
    acc_rsp = '0; wb_ready = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_unexpected", unexp, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_q_valid", acc_req.q_valid, 0);
    rst_i = 0;
    // single offload and write-back of x5
    cyc(1, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'hDEAD_BEEF, 0);
    idle();
    // RAW hazard on x7 stalls until the cycle after its write-back
    cyc(1, 1, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 7, 0, 0, 1, 1, 1, 32'h7777, 0);
    cyc(1, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    // fill to capacity, stall a wb offload, let a non-wb offload through
    for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, 5'(i), 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 8, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 8, 1, 1, 1, 32'h1111, 0);
    cyc(1, 1, 0, 0, 8, 1, 1, 1, 32'h2222, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 1, 1, $urandom(), 0);
    // simultaneous issue and retire, then back-to-back wrap
    cyc(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 9, 1, 1, 1, 32'h9999, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 5'(10 + i), 1, 1, 1, $urandom(), 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'hAAAA, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'hBBBB, 0);
    // back-pressured write-back with an error response
    cyc(1, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0, 32'hCAFE_F00D, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'hCAFE_F00D, 1);
    // orphan response, then asynchronous reset with two outstanding
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'h0BAD, 0);
    idle();
    cyc(1, 1, 0, 0, 4, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    core_q_valid = 0; acc_rsp.p_valid = 1; wb_ready = 0;
    #2;
    chk("pre_rst_wb_valid", wb_valid, 1);
    chk("pre_rst_outstanding", outstanding, 2);
    rst_i = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_unexpected", unexp, 0);
    chk("arst_q_valid", acc_req.q_valid, 0);
    @(posedge clk_i);
    #1;
    acc_rsp.p_valid = 0; wb_ready = 1;
    rst_i = 0;
    mq.delete();
    unexp_m = 0;
    hold = 0;
    idle();
    // random traffic on a small register window to provoke hazards and fullness
    for (int n = 0; n < 400; n++) begin
      bit pv;
      bit [31:0] d;
      bit e;
      pv = hold ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      d = hold ? last_d : $urandom();
      e = hold ? last_e : 1'($urandom_range(0, 7) == 0);
      cyc(1'($urandom()), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), pv, 1'($urandom()), d, e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
